// File: rtl/score_keeper_if.sv
// Point/clear inputs and score/status outputs of the score keeper.
//   pt_a, pt_b   : one-cycle "point won" pulses for player A / player B
//   clr          : start a new game
//   score_a_bcd  : player A score, [7:4] tens, [3:0] ones
//   score_b_bcd  : player B score, same format
//   game_over    : high while the game is over
//   winner       : 00 none, 01 A, 10 B, 11 draw
//   upd          : one-cycle strobe after a displayed score changed
interface score_keeper_if;
  logic       pt_a;
  logic       pt_b;
  logic       clr;
  logic [7:0] score_a_bcd;
  logic [7:0] score_b_bcd;
  logic       game_over;
  logic [1:0] winner;
  logic       upd;

  // Producer of points (point-counter side / testbench)
  modport master (
    output pt_a, pt_b, clr,
    input  score_a_bcd, score_b_bcd, game_over, winner, upd
  );

  // The score keeper itself
  modport slave (
    input  pt_a, pt_b, clr,
    output score_a_bcd, score_b_bcd, game_over, winner, upd
  );
endinterface

// File: rtl/score_keeper.sv
// Score keeper: counts per-player points as 2-digit BCD, detects the winning
// score and latches game-over plus the winner until the next clear.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, priority over everything
//   bus  : score_keeper_if.slave (pt_a, pt_b, clr in; scores/status out)
// All outputs come straight from flops.
module score_keeper #(
  parameter int unsigned WIN_SCORE = 11
) (
  input logic          clk,
  input logic          rst,
  score_keeper_if.slave bus
);

  localparam int unsigned BIN_W   = 7;
  localparam logic [BIN_W-1:0] WIN_BIN = BIN_W'(WIN_SCORE);

  typedef enum logic {
    PLAY = 1'b0,
    OVER = 1'b1
  } state_t;

  state_t     state, state_nx;
  logic [7:0] score_a, score_a_nx;
  logic [7:0] score_b, score_b_nx;
  logic       game_over, game_over_nx;
  logic [1:0] winner, winner_nx;
  logic       upd, upd_nx;

  logic [7:0] cand_a, cand_b;
  logic       win_a, win_b;

  // BCD +1 with saturation at 99
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two BCD digits to binary for the win compare
  function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [7:0] v);
    return BIN_W'(v[7:4]) * BIN_W'(10) + BIN_W'(v[3:0]);
  endfunction

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PLAY;
      score_a   <= 8'h00;
      score_b   <= 8'h00;
      game_over <= 1'b0;
      winner    <= 2'b00;
      upd       <= 1'b0;
    end else begin
      state     <= state_nx;
      score_a   <= score_a_nx;
      score_b   <= score_b_nx;
      game_over <= game_over_nx;
      winner    <= winner_nx;
      upd       <= upd_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx     = state;
    score_a_nx   = score_a;
    score_b_nx   = score_b;
    game_over_nx = game_over;
    winner_nx    = winner;
    upd_nx       = 1'b0;
    cand_a       = bus.pt_a ? bcd_inc(score_a) : score_a;
    cand_b       = bus.pt_b ? bcd_inc(score_b) : score_b;
    win_a        = (bcd_to_bin(cand_a) == WIN_BIN);
    win_b        = (bcd_to_bin(cand_b) == WIN_BIN);

    if (bus.clr) begin
      // Clear wins over any point in the same cycle; the point is dropped
      state_nx     = PLAY;
      score_a_nx   = 8'h00;
      score_b_nx   = 8'h00;
      game_over_nx = 1'b0;
      winner_nx    = 2'b00;
      upd_nx       = (score_a != 8'h00) || (score_b != 8'h00);
    end else begin
      unique case (state)
        PLAY: begin
          score_a_nx = cand_a;
          score_b_nx = cand_b;
          // Compare against the real change so a saturated 99 gives no strobe
          upd_nx     = (cand_a != score_a) || (cand_b != score_b);
          if (win_a || win_b) begin
            state_nx     = OVER;
            game_over_nx = 1'b1;
            winner_nx    = {win_b, win_a};
          end
        end
        OVER: begin
          // Points ignored; everything holds until clr or rst
        end
        default: state_nx = PLAY;
      endcase
    end
  end

  assign bus.score_a_bcd = score_a;
  assign bus.score_b_bcd = score_b;
  assign bus.game_over   = game_over;
  assign bus.winner      = winner;
  assign bus.upd         = upd;

endmodule
